return_address_stack: RTL

- Parametrised, clocked hardware return-address stack for the MIPS core; successor to the combinational JAL/JS stack-pointer logic.
- Push on JAL (saves return address); pop on JS (delivers the address to the PC mux).
- Adds configurable depth/width, registered storage, occupancy tracking, overflow/underflow detection and simultaneous push+pop handling.
- Sits between the decode stage (JAL/JS signals) and the PC-select logic.

---
 rtl/ras_pkg.sv | 18 +
 rtl/ras_ptr_ctrl.sv | 120 ++++++++++++
 rtl/return_address_stack.sv | 64 ++++++
 3 files changed

// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: operation encoding,
// reset data value and the JAL/JS decode helper.
package ras_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } ras_op_e;

    localparam logic RAS_RESET_DATA = 1'b0;

    function automatic ras_op_e decode_op(input logic jal, input logic js);
        return ras_op_e'({js, jal});
    endfunction

endpackage

// File: rtl/ras_ptr_ctrl.sv
// Pointer/occupancy controller for the return-address stack.
// `define RAS_WRAP_EN lets a push onto a full stack overwrite the oldest entry.
import ras_pkg::*;

module ras_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  ras_op_e          op_i,
    input  logic             clear_err_i,
    output logic [PTR_W:0]   count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic             store_o,
    output logic             load_o,
    output logic             we_o,
    output logic [PTR_W-1:0] wr_idx_o,
    output logic [PTR_W-1:0] rd_idx_o
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             store_q, store_d;
    logic             load_q, load_d;
    logic             ovf_set, unf_set;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == FULL_COUNT);
    assign rd_idx_o = sp_q - PTR_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        sp_d     = sp_q;
        count_d  = count_q;
        we_o     = 1'b0;
        wr_idx_o = sp_q;
        store_d  = 1'b0;
        load_d   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        case (op_i)
            OP_PUSH: begin
                if (!full_o) begin
                    we_o    = 1'b1;
                    sp_d    = sp_q + PTR_W'(1);
                    count_d = count_q + (PTR_W + 1)'(1);
                    store_d = 1'b1;
                end else begin
`ifdef RAS_WRAP_EN
                    we_o    = 1'b1;
                    sp_d    = sp_q + PTR_W'(1);
                    store_d = 1'b1;
`else
                    ovf_set = 1'b1;
`endif
                end
            end
            OP_POP: begin
                if (!empty_o) begin
                    sp_d    = sp_q - PTR_W'(1);
                    count_d = count_q - (PTR_W + 1)'(1);
                    load_d  = 1'b1;
                end else begin
                    unf_set = 1'b1;
                end
            end
            OP_REPLACE: begin
                we_o    = 1'b1;
                store_d = 1'b1;
                if (!empty_o) begin
                    wr_idx_o = rd_idx_o;
                    load_d   = 1'b1;
                end else begin
                    // An empty stack has nothing to replace, so this degrades to a push.
                    sp_d    = sp_q + PTR_W'(1);
                    count_d = count_q + (PTR_W + 1)'(1);
                end
            end
            default: ;
        endcase

        overflow_d  = ovf_set | (overflow_q  & ~clear_err_i);
        underflow_d = unf_set | (underflow_q & ~clear_err_i);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            store_q     <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            store_q     <= store_d;
            load_q      <= load_d;
        end
    end

    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
    assign store_o     = store_q;
    assign load_o      = load_q;

endmodule

// File: rtl/return_address_stack.sv
// Clocked return-address stack: push on JAL, pop on JS, register-array storage.
// `define RAS_WRAP_EN to accept pushes onto a full stack by overwriting the oldest entry.
import ras_pkg::*;

module return_address_stack #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              JAL_signal,
    input  logic              JS_signal,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clear_err,
    output logic [DATA_W-1:0] Top_Stack,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              Store_RAM_signal,
    output logic              Load_RAM_signal
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              we;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  rd_idx;

    ras_ptr_ctrl #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .op_i        (decode_op(JAL_signal, JS_signal)),
        .clear_err_i (clear_err),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .underflow_o (underflow),
        .store_o     (Store_RAM_signal),
        .load_o      (Load_RAM_signal),
        .we_o        (we),
        .wr_idx_o    (wr_idx),
        .rd_idx_o    (rd_idx)
    );

    // NOTE: the storage is small flop-based state that must read back as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{RAS_RESET_DATA}};
            end
        end else if (we) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign Top_Stack = empty ? {DATA_W{RAS_RESET_DATA}} : mem_q[rd_idx];

endmodule
